// File: rtl/instr_loader.sv
// Boot-time program loader: streams instruction words into imem over valid/ready,
// then releases the CPU via cpu_start_o after a settle delay.
module instr_loader #(
    parameter int DEPTH       = 32,
    parameter int WORD_W      = 32,
    parameter int START_DELAY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic [6:0]        word_count_i,
    input  logic              data_valid_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              data_ready_o,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [WORD_W-1:0] imem_data_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(START_DELAY + 2);

    state_t              state_q;
    logic [6:0]          index_q;
    logic [6:0]          count_q;
    logic [CNT_W-1:0]    settle_q;
    logic                ready_q;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [WORD_W-1:0]   data_q;
    logic                start_q;
    logic                busy_q;
    logic                err_q;

    logic                req_legal_d;
    logic                xfer_d;
    logic                last_xfer_d;

    assign req_legal_d = (word_count_i != 7'd0) && (word_count_i <= 7'(DEPTH));
    assign xfer_d      = (state_q == S_LOAD) && ready_q && data_valid_i;
    assign last_xfer_d = xfer_d && (index_q == (count_q - 7'd1));

    // Loader FSM; every output is a register updated here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            index_q  <= 7'd0;
            count_q  <= 7'd0;
            settle_q <= '0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            data_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (xfer_d) begin
                we_q    <= 1'b1;
                addr_q  <= {23'd0, index_q, 2'b00};
                data_q  <= data_i;
                index_q <= index_q + 7'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (load_req_i) begin
                        if (req_legal_d) begin
                            state_q <= S_LOAD;
                            index_q <= 7'd0;
                            count_q <= word_count_i;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // load_req_i is deliberately not looked at while loading
                    if (last_xfer_d) begin
                        state_q  <= S_SETTLE;
                        ready_q  <= 1'b0;
                        settle_q <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == CNT_W'(START_DELAY)) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b0;
                        start_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_RUN: begin
                    if (load_req_i) begin
                        start_q <= 1'b0;
                        if (req_legal_d) begin
                            state_q <= S_LOAD;
                            index_q <= 7'd0;
                            count_q <= word_count_i;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    if (load_req_i && req_legal_d) begin
                        state_q <= S_LOAD;
                        err_q   <= 1'b0;
                        index_q <= 7'd0;
                        count_q <= word_count_i;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    we_q    <= 1'b0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign cpu_start_o  = start_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: cycle-by-cycle vector table plus a full-depth
// load sequence. Outputs are sampled 1 time unit after each rising edge.
module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic [6:0]  word_count;
    logic        data_valid;
    logic [31:0] data_in;
    logic        data_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        cpu_start;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_loader #(.DEPTH(32), .WORD_W(32), .START_DELAY(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_req_i   (load_req),
        .word_count_i (word_count),
        .data_valid_i (data_valid),
        .data_i       (data_in),
        .data_ready_o (data_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .cpu_start_o  (cpu_start),
        .busy_o       (busy),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic [6:0]  cnt;
        logic        valid;
        logic [31:0] din;
        logic        ready;
        logic        we;
        logic [31:0] addr;
        logic [31:0] dout;
        logic        start;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic q, input logic [6:0] c, input logic v,
                       input logic [31:0] d, input logic e_rdy, input logic e_we,
                       input logic [31:0] e_addr, input logic [31:0] e_dat,
                       input logic e_st, input logic e_bsy, input logic e_err);
        vec_t t;
        t.rst = r; t.req = q; t.cnt = c; t.valid = v; t.din = d;
        t.ready = e_rdy; t.we = e_we; t.addr = e_addr; t.dout = e_dat;
        t.start = e_st; t.busy = e_bsy; t.err = e_err;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] pack_out(input logic r, input logic w, input logic [31:0] a,
                                             input logic [31:0] d, input logic s,
                                             input logic b, input logic e);
        return {r, w, a, d, s, b, e};
    endfunction

    localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002, WC = 32'hC000_0003;
    localparam logic [31:0] WD = 32'hD000_0004, WE = 32'hE000_0005, WF = 32'hF000_0006;
    localparam logic [31:0] WG = 32'h1234_5678, WH = 32'h0BAD_F00D, WI = 32'h0DEA_DBEE;
    localparam logic [31:0] WJ = 32'h1111_0001, WK = 32'h2222_0002, WL = 32'h3333_0003;
    localparam logic [31:0] WX = 32'h5A5A_5A5A;

    initial begin
        int we_pulses;
        int extra_we;
        logic start_seen;
        logic both_high;

        //   rst  req cnt    vld din   | rdy we addr    data  st  bsy err
        // 1: count=4 back-to-back, settle, run
        add(1'b1,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,7'd4, 1'b0,32'd0, 1'b1,1'b0,32'd0, 32'd0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WA,    1'b1,1'b1,32'd0, WA,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WB,    1'b1,1'b1,32'd4, WB,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WC,    1'b1,1'b1,32'd8, WC,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WD,    1'b0,1'b1,32'd12,WD,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd12,WD,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd12,WD,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd12,WD,   1'b1,1'b0,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WX,    1'b0,1'b0,32'd12,WD,   1'b1,1'b0,1'b0);
        // 4: reload from RUN with count=2
        add(1'b0,1'b1,7'd2, 1'b0,32'd0, 1'b1,1'b0,32'd12,WD,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WE,    1'b1,1'b1,32'd0, WE,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WF,    1'b0,1'b1,32'd4, WF,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd4, WF,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd4, WF,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd4, WF,   1'b1,1'b0,1'b0);
        // 3: illegal counts 0 and 33, then a legal request clears err
        add(1'b1,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b1);
        add(1'b0,1'b0,7'd0, 1'b1,WX,    1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,7'd33,1'b1,WX,    1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,7'd1, 1'b0,32'd0, 1'b1,1'b0,32'd0, 32'd0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WG,    1'b0,1'b1,32'd0, WG,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd0, WG,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd0, WG,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd0, WG,   1'b1,1'b0,1'b0);
        // 5: reset after 2nd of 5 words, then valid is ignored
        add(1'b1,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,7'd5, 1'b0,32'd0, 1'b1,1'b0,32'd0, 32'd0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WH,    1'b1,1'b1,32'd0, WH,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WI,    1'b1,1'b1,32'd4, WI,   1'b0,1'b1,1'b0);
        add(1'b1,1'b0,7'd0, 1'b1,WX,    1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WX,    1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WX,    1'b0,1'b0,32'd0, 32'd0,1'b0,1'b0,1'b0);
        // 2: count=3 with valid gaps 1,0,0,1,0,1; a request mid-load is ignored
        add(1'b0,1'b1,7'd3, 1'b0,32'd0, 1'b1,1'b0,32'd0, 32'd0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WJ,    1'b1,1'b1,32'd0, WJ,   1'b0,1'b1,1'b0);
        add(1'b0,1'b1,7'd1, 1'b0,WX,    1'b1,1'b0,32'd0, WJ,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,WX,    1'b1,1'b0,32'd0, WJ,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WK,    1'b1,1'b1,32'd4, WK,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b1,1'b0,32'd4, WK,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WL,    1'b0,1'b1,32'd8, WL,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b1,WX,    1'b0,1'b0,32'd8, WL,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd8, WL,   1'b0,1'b1,1'b0);
        add(1'b0,1'b0,7'd0, 1'b0,32'd0, 1'b0,1'b0,32'd8, WL,   1'b1,1'b0,1'b0);

        rst = 1'b1; load_req = 1'b0; word_count = 7'd0; data_valid = 1'b0; data_in = 32'd0;

        foreach (tbl[i]) begin
            rst        = tbl[i].rst;
            load_req   = tbl[i].req;
            word_count = tbl[i].cnt;
            data_valid = tbl[i].valid;
            data_in    = tbl[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                pack_out(data_ready, imem_we, imem_addr, imem_data, cpu_start, busy, err),
                pack_out(tbl[i].ready, tbl[i].we, tbl[i].addr, tbl[i].dout,
                         tbl[i].start, tbl[i].busy, tbl[i].err));
        end

        // 6: full 32-word load, last address 124, no wrap or extra write
        rst = 1'b1; load_req = 1'b0; data_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; load_req = 1'b1; word_count = 7'd32;
        @(posedge clk); #1;
        load_req = 1'b0;
        we_pulses = 0;
        for (int i = 0; i < 32; i++) begin
            data_valid = 1'b1;
            data_in    = 32'h7700_0000 + 32'(i);
            @(posedge clk); #1;
            if (imem_we) we_pulses++;
            chk($sformatf("full_w%0d", i), {37'd0, imem_we, imem_addr},
                {37'd0, 1'b1, 32'(i * 4)});
        end
        extra_we = 0;
        start_seen = 1'b0;
        both_high = 1'b0;
        for (int c = 0; c < 10 && !start_seen; c++) begin
            data_valid = 1'b1;
            data_in    = WX;
            @(posedge clk); #1;
            if (imem_we) extra_we++;
            if (cpu_start && busy) both_high = 1'b1;
            if (cpu_start) start_seen = 1'b1;
        end
        data_valid = 1'b0;
        chk("full_start_seen", {68'd0, start_seen}, {68'd0, 1'b1});
        chk("full_extra_we", 69'(extra_we), 69'd0);
        chk("full_we_total", 69'(we_pulses), 69'd32);
        chk("full_last_addr", {37'd0, imem_addr}, {37'd0, 32'd124});
        chk("full_start_busy_excl", {68'd0, both_high}, {68'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
